// File: rtl/avalon_aes_master_if.sv
// Avalon-MM master-side bus bundle for the AES decryption sequencer.
// The master drives the strobes, address and write data. The slave returns read data.
interface avalon_aes_master_if;
  logic        AVL_READ;
  logic        AVL_WRITE;
  logic        AVL_CS;
  logic [3:0]  AVL_ADDR;
  logic [3:0]  AVL_BYTE_EN;
  logic [31:0] AVL_WRITEDATA;
  logic [31:0] AVL_READDATA;

  modport master (
    output AVL_READ, AVL_WRITE, AVL_CS, AVL_ADDR, AVL_BYTE_EN, AVL_WRITEDATA,
    input  AVL_READDATA
  );

  modport slave (
    input  AVL_READ, AVL_WRITE, AVL_CS, AVL_ADDR, AVL_BYTE_EN, AVL_WRITEDATA,
    output AVL_READDATA
  );
endinterface

// File: rtl/avalon_aes_master.sv
// Sequences one AES decryption on an Avalon-MM slave: load key and message, start,
// poll done, read result, clear start. Writes take two cycles (setup, then strobe).
module avalon_aes_master #(
  parameter int unsigned POLL_MAX = 1024
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic [127:0]         KEY,
  input  logic [127:0]         MSG_ENC,
  output logic [127:0]         MSG_DEC,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 TIMEOUT,
  avalon_aes_master_if.master  avl
);

  localparam int unsigned PW = $clog2(POLL_MAX) + 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_STROBE, POLL, RD, CLR_SETUP, CLR_STROBE
  } state_t;

  state_t         r_state, w_next;
  logic [127:0]   r_key, r_msg, r_msg_dec;
  logic [3:0]     r_idx;
  logic [PW-1:0]  r_poll;
  logic           r_ok;
  logic [3:0]     w_wr_addr;
  logic [31:0]    w_wr_data;

  assign MSG_DEC = r_msg_dec;

  // Write sequence table: key words, message words, clear done, then start.
  always_comb begin
    w_wr_addr = r_idx;
    w_wr_data = '0;
    case (r_idx)
      4'd0: w_wr_data = r_key[127:96];
      4'd1: w_wr_data = r_key[95:64];
      4'd2: w_wr_data = r_key[63:32];
      4'd3: w_wr_data = r_key[31:0];
      4'd4: w_wr_data = r_msg[127:96];
      4'd5: w_wr_data = r_msg[95:64];
      4'd6: w_wr_data = r_msg[63:32];
      4'd7: w_wr_data = r_msg[31:0];
      4'd8: w_wr_addr = 4'd15;
      4'd9: begin w_wr_addr = 4'd14; w_wr_data = 32'h1; end
      default: w_wr_data = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next             = r_state;
    avl.AVL_READ       = 1'b0;
    avl.AVL_WRITE      = 1'b0;
    avl.AVL_CS         = 1'b0;
    avl.AVL_ADDR       = '0;
    avl.AVL_BYTE_EN    = '0;
    avl.AVL_WRITEDATA  = '0;
    BUSY               = (r_state != IDLE);
    DONE               = 1'b0;
    TIMEOUT            = 1'b0;
    case (r_state)
      IDLE: if (START) w_next = WR_SETUP;
      WR_SETUP, WR_STROBE: begin
        avl.AVL_ADDR      = w_wr_addr;
        avl.AVL_WRITEDATA = w_wr_data;
        avl.AVL_BYTE_EN   = 4'hF;
        if (r_state == WR_SETUP) begin
          w_next = WR_STROBE;
        end else begin
          avl.AVL_WRITE = 1'b1;
          avl.AVL_CS    = 1'b1;
          w_next        = (r_idx == 4'd9) ? POLL : WR_SETUP;
        end
      end
      POLL: begin
        avl.AVL_READ = 1'b1;
        avl.AVL_CS   = 1'b1;
        avl.AVL_ADDR = 4'd15;
        if (avl.AVL_READDATA[0]) begin
          w_next = RD;
        end else if (r_poll == POLL_LAST) begin
          TIMEOUT = 1'b1;
          w_next  = CLR_SETUP;
        end
      end
      RD: begin
        avl.AVL_READ = 1'b1;
        avl.AVL_CS   = 1'b1;
        avl.AVL_ADDR = {2'b10, r_idx[1:0]};
        if (r_idx[1:0] == 2'd3) w_next = CLR_SETUP;
      end
      CLR_SETUP, CLR_STROBE: begin
        avl.AVL_ADDR    = 4'd14;
        avl.AVL_BYTE_EN = 4'hF;
        if (r_state == CLR_SETUP) begin
          w_next = CLR_STROBE;
        end else begin
          avl.AVL_WRITE = 1'b1;
          avl.AVL_CS    = 1'b1;
          DONE          = r_ok;
          w_next        = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_key     <= '0;
      r_msg     <= '0;
      r_msg_dec <= '0;
      r_idx     <= '0;
      r_poll    <= '0;
      r_ok      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (START) begin
          r_key <= KEY;
          r_msg <= MSG_ENC;
          r_idx <= '0;
          r_ok  <= 1'b0;
        end
        WR_STROBE: begin
          if (r_idx == 4'd9) begin
            r_idx  <= '0;
            r_poll <= '0;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        POLL: begin
          if (avl.AVL_READDATA[0]) begin
            r_idx <= '0;
            r_ok  <= 1'b1;
          end else if (r_poll != POLL_LAST) begin
            r_poll <= r_poll + 1'b1;
          end
        end
        RD: begin
          case (r_idx[1:0])
            2'd0: r_msg_dec[31:0]   <= avl.AVL_READDATA;
            2'd1: r_msg_dec[63:32]  <= avl.AVL_READDATA;
            2'd2: r_msg_dec[95:64]  <= avl.AVL_READDATA;
            2'd3: r_msg_dec[127:96] <= avl.AVL_READDATA;
            default: r_msg_dec[31:0] <= avl.AVL_READDATA;
          endcase
          r_idx <= r_idx + 4'd1;
        end
        default: r_idx <= r_idx;
      endcase
    end
  end

endmodule

// File: doc/avalon_aes_master.md
AVALON_AES_MASTER -- requirements
Module: avalon_aes_master

Interface
REQ-001 SHALL have parameter: POLL_MAX, 1024, maximum done-register reads before abort.
REQ-002 SHALL have port: CLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: RESET  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: START  input  1  one-cycle request to run one decryption; sampled only in IDLE.
REQ-005 SHALL have port: KEY  input  128  AES key; KEY[127:96] is word 0; captured on accepted START.
REQ-006 SHALL have port: MSG_ENC  input  128  encrypted message; MSG_ENC[127:96] is word 4; captured on accepted START.
REQ-007 SHALL have port: MSG_DEC  output  128  decrypted message, registered.
REQ-008 SHALL have port: BUSY  output  1  high in every state except IDLE.
REQ-009 SHALL have port: DONE  output  1  one-cycle pulse on successful completion.
REQ-010 SHALL have port: TIMEOUT  output  1  one-cycle pulse on poll abort.
REQ-011 SHALL have ports: AVL_READ, AVL_WRITE, AVL_CS  output  1 each  Avalon-MM master strobes.
REQ-012 SHALL have ports: AVL_ADDR  output  4; AVL_BYTE_EN  output  4; AVL_WRITEDATA  output  32; AVL_READDATA  input  32.

Function
REQ-013 SHALL use states IDLE, WR_SETUP, WR_STROBE, POLL, RD, CLR_SETUP, CLR_STROBE.
REQ-014 SHALL, in IDLE with START=1, capture KEY/MSG_ENC, clear write index to 0, go to WR_SETUP; START outside IDLE is ignored.
REQ-015 SHALL perform every write in two cycles: WR_SETUP drives AVL_ADDR, AVL_WRITEDATA, AVL_BYTE_EN=4'hF with AVL_WRITE=AVL_CS=0; WR_STROBE holds identical ADDR/DATA/BYTE_EN with AVL_WRITE=AVL_CS=1 (slave latches write data one cycle early).
REQ-016 SHALL issue writes in index order 0..9: addr 0-3 = KEY words 127:96..31:0; addr 4-7 = MSG_ENC words 127:96..31:0; addr 15 data 32'h0 (clear done); addr 14 data 32'h1 (start).
REQ-017 SHALL go WR_STROBE -> WR_SETUP with index+1 when index<9; index=9 -> POLL with poll counter cleared.
REQ-018 SHALL, in POLL, assert AVL_READ=AVL_CS=1, AVL_ADDR=15 each cycle and sample AVL_READDATA same cycle (zero wait-state read).
REQ-019 SHALL leave POLL to RD (read index 0) when sampled AVL_READDATA[0]=1; else increment poll counter.
REQ-020 SHALL, when poll counter reaches POLL_MAX-1 without done, pulse TIMEOUT and go to CLR_SETUP; MSG_DEC unchanged.
REQ-021 SHALL, in RD, read addr 8+index for index 0..3, one per cycle, AVL_READ=AVL_CS=1, storing addr 8 -> MSG_DEC[31:0], 9 -> [63:32], 10 -> [95:64], 11 -> [127:96]; after index 3 go to CLR_SETUP.
REQ-022 SHALL, in CLR_SETUP/CLR_STROBE, write addr 14 data 32'h0 per REQ-015, then return to IDLE; DONE pulses in the CLR_STROBE cycle on success, not after timeout.
REQ-023 SHALL never assert AVL_READ and AVL_WRITE together; in IDLE all strobes 0, AVL_ADDR=0, AVL_WRITEDATA=0, AVL_BYTE_EN=0.
REQ-024 SHALL size poll counter to clog2(POLL_MAX)+1 bits, no wrap.
REQ-025 SHALL, if START coincides with DONE or TIMEOUT cycle, ignore it (state not yet IDLE).

Reset
REQ-026 SHALL, on RESET=0, immediately force IDLE, index/poll counters 0, MSG_DEC=0, BUSY=DONE=TIMEOUT=0, all Avalon outputs 0, regardless of CLK.
REQ-027 SHALL, on reset mid-transaction, abandon it without issuing further bus cycles; no DONE or TIMEOUT pulse.
REQ-028 SHALL resume on first rising CLK edge after RESET returns high.

Verification
REQ-029 SHALL check: KEY=128'h000102030405060708090a0b0c0d0e0f, START pulse -> ten 2-cycle writes, addr 0 data 32'h00010203 ... addr 14 data 32'h1, each strobe preceded by identical setup cycle.
REQ-030 SHALL check: slave model returns done=1 on 3rd poll, reads 8-11 return 32'hA, B, C, D -> MSG_DEC=128'h0000000D_0000000C_0000000B_0000000A, DONE one cycle, BUSY low next cycle.
REQ-031 SHALL check: POLL_MAX=8, done never set -> exactly 8 reads of addr 15, TIMEOUT one pulse, addr 14 written 0, no DONE.
REQ-032 SHALL check: RESET low during WR_STROBE index 5 -> outputs 0 asynchronously, no further bus activity, next START restarts at addr 0.
REQ-033 SHALL check: START held high throughout a run -> exactly one transaction, START ignored on DONE cycle, next accepted in IDLE.
